bomb_put_ctrl: RTL

BOMB_PUT_CTRL -- requirements
Module: bomb_put_ctrl

---
 rtl/bomb_pkg.sv | 26 ++
 rtl/bomb_put_ctrl_if.sv | 32 +++
 rtl/bomb_slot_timer.sv | 62 ++++++
 rtl/bomb_put_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/bomb_pkg.sv
// Shared bomb-game definitions: wall tile codes, player ids, default fuse/capacity, cap clamp.
// No logic and no latency; types and constants only.
package bomb_pkg;

    typedef enum logic [1:0] {
        EMPTY_WALL  = 2'd0,
        ABLE_WALL   = 2'd1,
        UNABLE_WALL = 2'd2
    } wall_e;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    localparam int FUSE_TICKS_DEF = 61;
    localparam int MAX_CAP_DEF    = 4;

    // A zero capacity acts as one bomb; anything above the slot count saturates.
    function automatic logic [2:0] clamp_cap(input logic [2:0] cap, input int max_cap);
        logic [2:0] lim;
        lim = 3'(max_cap);
        if (cap == 3'd0) return 3'd1;
        if (cap > lim)   return lim;
        return cap;
    endfunction

endpackage

// File: rtl/bomb_put_ctrl_if.sv
// Put-controller bundle: player buttons/positions/caps, tile maps and the registered strobes.
// Pure wiring; master drives requests and maps, slave drives strobes and counts.
interface bomb_put_ctrl_if;
    logic         frame_tick;
    logic         p1_req;
    logic         p2_req;
    logic [7:0]   p1_cor;
    logic [7:0]   p2_cor;
    logic [2:0]   p1_cap;
    logic [2:0]   p2_cap;
    logic [255:0] bomb_un_grid;
    logic [255:0] wall_block;
    logic         p1_put;
    logic         p2_put;
    logic [2:0]   p1_active;
    logic [2:0]   p2_active;
    logic         p1_reject;
    logic         p2_reject;
    logic         rr_prio;

    modport master (
        output frame_tick, p1_req, p2_req, p1_cor, p2_cor, p1_cap, p2_cap,
               bomb_un_grid, wall_block,
        input  p1_put, p2_put, p1_active, p2_active, p1_reject, p2_reject, rr_prio
    );

    modport slave (
        input  frame_tick, p1_req, p2_req, p1_cor, p2_cor, p1_cap, p2_cap,
               bomb_un_grid, wall_block,
        output p1_put, p2_put, p1_active, p2_active, p1_reject, p2_reject, rr_prio
    );
endinterface

// File: rtl/bomb_slot_timer.sv
// One player's bomb slots: allocate lowest free slot, age on frame_tick, free at fuse end.
// Allocation/free take effect next cycle; no backpressure, caller only allocates below capacity.
module bomb_slot_timer #(
    parameter int FUSE_TICKS = 61,
    parameter int MAX_CAP    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       alloc,
    output logic [2:0] active
);
    localparam int            CW   = (FUSE_TICKS > 2) ? $clog2(FUSE_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(FUSE_TICKS - 1);

    logic [MAX_CAP-1:0] occ_q, occ_d;
    logic [CW-1:0]      cnt_q [MAX_CAP];
    logic [CW-1:0]      cnt_d [MAX_CAP];
    logic               placed;

    always_comb begin
        occ_d  = occ_q;
        cnt_d  = cnt_q;
        placed = 1'b0;
        for (int i = 0; i < MAX_CAP; i++) begin
            if (occ_q[i] && frame_tick) begin
                if (cnt_q[i] == LAST) begin
                    occ_d[i] = 1'b0;
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            // A slot freeing this cycle is still occupied here, so it is reused next cycle at the earliest.
            if (alloc && !placed && !occ_q[i]) begin
                occ_d[i] = 1'b1;
                cnt_d[i] = '0;
                placed   = 1'b1;
            end
        end
    end

    always_comb begin
        active = '0;
        for (int i = 0; i < MAX_CAP; i++) begin
            active = active + 3'(occ_q[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
            for (int i = 0; i < MAX_CAP; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bomb_put_ctrl.sv
// Turns put-button presses into one-cycle put/reject strobes (1-cycle latency, nothing queued, no backpressure).
// BOMB_PUT_RR_EN: same-tile conflicts alternate between players; otherwise P1 always wins.
module bomb_put_ctrl
    import bomb_pkg::*;
#(
    parameter int FUSE_TICKS = FUSE_TICKS_DEF,
    parameter int MAX_CAP    = MAX_CAP_DEF
) (
    input  logic           clk,
    input  logic           reset,
    bomb_put_ctrl_if.slave bus
);
    logic [1:0] req_prev_q, req_prev_d;
    logic [1:0] put_q, put_d;
    logic [1:0] rej_q, rej_d;
    logic [7:0] tile_q [2];
    logic [7:0] tile_d [2];
    logic       rr_prio_q, rr_prio_d;

    logic [1:0] press, legal, grant;
    logic [7:0] cor    [2];
    logic [2:0] cap    [2];
    logic [2:0] active [2];
    logic       clash, winner;

    assign cor[0] = bus.p1_cor;
    assign cor[1] = bus.p2_cor;
    assign cap[0] = clamp_cap(bus.p1_cap, MAX_CAP);
    assign cap[1] = clamp_cap(bus.p2_cap, MAX_CAP);

    always_comb begin
        req_prev_d = {bus.p2_req, bus.p1_req};
        press      = {bus.p2_req, bus.p1_req} & ~req_prev_q;
        legal      = '0;
        // Tiles of the puts on the wire now are not yet visible in bomb_un_grid.
        for (int p = 0; p < 2; p++) begin
            legal[p] = press[p]
                     && !bus.bomb_un_grid[cor[p]]
                     && !bus.wall_block[cor[p]]
                     && !(put_q[0] && cor[p] == tile_q[0])
                     && !(put_q[1] && cor[p] == tile_q[1])
                     && (active[p] < cap[p]);
        end
        clash = legal[0] && legal[1] && (cor[0] == cor[1]);
`ifdef BOMB_PUT_RR_EN
        winner    = rr_prio_q;
        rr_prio_d = clash ? ~rr_prio_q : rr_prio_q;
`else
        winner    = P1;
        rr_prio_d = 1'b0;
`endif
        grant = legal;
        if (clash) begin
            if (winner == P1) grant[1] = 1'b0;
            else              grant[0] = 1'b0;
        end
        put_d = grant;
        rej_d = press & ~grant;
        for (int p = 0; p < 2; p++) begin
            tile_d[p] = grant[p] ? cor[p] : tile_q[p];
        end
    end

    // Edge history resets to "held" so a button held across reset needs a release first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_prev_q <= 2'b11;
            put_q      <= '0;
            rej_q      <= '0;
            tile_q[0]  <= '0;
            tile_q[1]  <= '0;
            rr_prio_q  <= 1'b0;
        end else begin
            req_prev_q <= req_prev_d;
            put_q      <= put_d;
            rej_q      <= rej_d;
            tile_q     <= tile_d;
            rr_prio_q  <= rr_prio_d;
        end
    end

    bomb_slot_timer #(.FUSE_TICKS(FUSE_TICKS), .MAX_CAP(MAX_CAP)) u_p1_slots (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (bus.frame_tick),
        .alloc      (grant[0]),
        .active     (active[0])
    );

    bomb_slot_timer #(.FUSE_TICKS(FUSE_TICKS), .MAX_CAP(MAX_CAP)) u_p2_slots (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (bus.frame_tick),
        .alloc      (grant[1]),
        .active     (active[1])
    );

    assign bus.p1_put    = put_q[0];
    assign bus.p2_put    = put_q[1];
    assign bus.p1_reject = rej_q[0];
    assign bus.p2_reject = rej_q[1];
    assign bus.p1_active = active[0];
    assign bus.p2_active = active[1];
    assign bus.rr_prio   = rr_prio_q;

endmodule
